multi_cycle_ctrl: RTL
=====================

Name: multi_cycle_ctrl

Overview:
- Moore-style control FSM that sequences a multi-cycle MIPS-subset datapath: shared ALU, single unified memory port, instruction register (IR), ALUOut register.
- Replaces the single-cycle combinational decoder when the datapath is converted to multi-cycle with a wait-stated memory.
- Drives all mux selects and write enables from a registered state.
- Handles the memory ready handshake, memory timeout and illegal-opcode trapping.

Parameters:
- MEM_TIMEOUT, 15: max cycles to wait for mem_ready_i in one memory state, range 1..255; 0 disables the timeout.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  synchronous, active-high reset
- op_i  input  6  IR[31:26], registered externally, stable after FETCH completes
- zero_i  input  1  ALU zero flag
- mem_ready_i  input  1  memory completes the current access this cycle
- pc_write_o  output  1  PC load enable
- ir_write_o  output  1  IR load enable
- reg_write_o  output  1  register-file write enable
- mem_read_o  output  1  memory read strobe
- mem_write_o  output  1  memory write strobe
- i_or_d_o  output  1  memory address select: 0 = PC, 1 = ALUOut
- alu_src_a_o  output  1  0 = PC, 1 = RS register
- alu_src_b_o  output  2  00 = RT, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op_o  output  3  000 add, 001 sub, 010 use funct, 011 slt
- pc_source_o  output  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}
- reg_dst_o  output  1  0 = rt, 1 = rd
- mem_to_reg_o  output  1  0 = ALUOut, 1 = memory data
- state_o  output  4  current state code (debug)
- err_o  output  1  sticky error flag
- cycle_cnt_o  output  32  cycle counter (optional feature)
- instr_cnt_o  output  32  retired-instruction counter (optional feature)

Behaviour:
- Reset: state <= FETCH (0), wait counter <= 0, err_o = 0, counters <= 0.
- While rst_i = 1, all enables and strobes are forced to 0: pc_write, ir_write, reg_write, mem_read, mem_write.
- Outputs are decoded combinationally from the registered state, plus zero_i and mem_ready_i where noted. Unlisted selects are 0 and unlisted enables are 0.
- State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, ERR=15.
- FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=add, pc_source=00. When mem_ready_i: ir_write=1, pc_write=1, next state DECODE. Otherwise hold.
- DECODE: src_a=0, src_b=11, alu_op=add (branch target latched into ALUOut). Next state by op_i:
  - 0x00 -> R_EXEC
  - 0x08, 0x0A -> I_EXEC
  - 0x23, 0x2B -> MEM_ADDR
  - 0x04, 0x05 -> BRANCH
  - 0x02 -> JUMP
  - any other opcode -> ERR
- MEM_ADDR: src_a=1, src_b=10, add. Next MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: mem_read=1, i_or_d=1. On ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1, held until ready. On ready -> FETCH.
- R_EXEC: src_a=1, src_b=00, alu_op=010 -> R_WB.
- R_WB: reg_dst=1, reg_write=1 -> FETCH.
- I_EXEC: src_a=1, src_b=10; alu_op=000 for 0x08, 011 for 0x0A -> I_WB.
- I_WB: reg_dst=0, reg_write=1 -> FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=001, pc_source=01. pc_write=zero_i for 0x04, ~zero_i for 0x05 -> FETCH.
- JUMP: pc_source=10, pc_write=1 -> FETCH.
- ERR: all enables 0, err_o=1. Exits only via rst_i.
- Latency in cycles with zero wait states: R-type 4, I-type 4, lw 5, sw 4, branch 3, jump 3. Each wait cycle adds 1.
- Wait counter (8 bit):
  - Cleared on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle in those states while mem_ready_i = 0.
  - If the counter equals MEM_TIMEOUT and mem_ready_i = 0 (MEM_TIMEOUT != 0): next state ERR, with no enable asserted that cycle.
  - mem_ready_i = 1 in the same cycle as the timeout: ready wins.
- mem_ready_i is ignored outside memory states.
- Reset mid-access (any state, any wait count): return to FETCH next cycle, with no write enables in the reset cycle.

Optional Feature:
- Macro: MULTI_CYCLE_CTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt_o increments every cycle with rst_i = 0 and state != ERR.
  - instr_cnt_o increments on each transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH or JUMP.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 32'd0 and no counter flops are built.

Test Plan:
- Reset: hold rst_i for 2 cycles, mem_ready_i=1 -> state_o=0, all enables 0 during reset, err_o=0; mem_read_o=1 on the first cycle after release.
- R-type add: op_i=0x00, mem_ready_i=1 -> states 0,1,6,7,0; reg_write_o=1 and reg_dst_o=1 only in cycle 4; instr_cnt_o=1 when feature enabled.
- lw with 2 wait states in MEM_RD: op_i=0x23 -> states 0,1,2,3,3,3,4,0; mem_read_o and i_or_d_o high for 3 cycles; mem_to_reg_o=1 in MEM_WB.
- Branch: beq with zero_i=1 -> pc_write_o=1, pc_source_o=01 in BRANCH; bne with zero_i=1 -> pc_write_o=0; each takes 3 cycles.
- Illegal opcode 0x3F -> ERR after DECODE, err_o=1 sticky for 20 cycles, no enables asserted; rst_i clears it.
- Timeout with MEM_TIMEOUT=3: mem_ready_i held at 0 in FETCH -> ERR entered after 4 cycles in FETCH. Repeat with ready asserted on the 4th cycle -> DECODE, no error.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS-subset datapath with wait-stated memory.
// Optional performance counters are built when MULTI_CYCLE_CTRL_PERF_CNT_EN is defined.
module multi_cycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  op_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        i_or_d_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic [1:0]  pc_source_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic [3:0]  state_o,
    output logic        err_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE = 4'd1,  MEM_ADDR = 4'd2,  MEM_RD = 4'd3,
        MEM_WB   = 4'd4,  MEM_WR = 4'd5,  R_EXEC   = 4'd6,  R_WB   = 4'd7,
        BRANCH   = 4'd8,  JUMP   = 4'd9,  I_EXEC   = 4'd10, I_WB   = 4'd11,
        ERR      = 4'd15
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_state_s;
    logic       timeout_s;
    logic       pc_write_s, ir_write_s, reg_write_s, mem_read_s, mem_write_s;

    assign mem_state_s = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    // A ready in the same cycle as the limit is reached still completes the access.
    assign timeout_s   = mem_state_s && !mem_ready_i && (TIMEOUT_C != 8'd0) && (wait_q == TIMEOUT_C);

    // State and wait-counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = timeout_s ? ERR : (mem_ready_i ? DECODE : FETCH);
            DECODE: begin
                case (op_i)
                    6'h00:        state_d = R_EXEC;
                    6'h08, 6'h0A: state_d = I_EXEC;
                    6'h23, 6'h2B: state_d = MEM_ADDR;
                    6'h04, 6'h05: state_d = BRANCH;
                    6'h02:        state_d = JUMP;
                    default:      state_d = ERR;
                endcase
            end
            MEM_ADDR: state_d = (op_i == 6'h23) ? MEM_RD : ((op_i == 6'h2B) ? MEM_WR : ERR);
            MEM_RD:   state_d = timeout_s ? ERR : (mem_ready_i ? MEM_WB : MEM_RD);
            MEM_WR:   state_d = timeout_s ? ERR : (mem_ready_i ? FETCH : MEM_WR);
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_d = FETCH;
            R_EXEC:   state_d = R_WB;
            I_EXEC:   state_d = I_WB;
            ERR:      state_d = ERR;
            default:  state_d = ERR;
        endcase

        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (mem_state_s && !mem_ready_i) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    // Datapath control decode from the registered state
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        i_or_d_o     = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b000;
        pc_source_o  = 2'b00;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        err_o        = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_s  = mem_ready_i;
                pc_write_s  = mem_ready_i;
            end
            DECODE:   alu_src_b_o = 2'b11;
            MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            MEM_RD: begin
                mem_read_s = 1'b1;
                i_or_d_o   = 1'b1;
            end
            MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            MEM_WR: begin
                mem_write_s = 1'b1;
                i_or_d_o    = 1'b1;
            end
            R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b010;
            end
            R_WB: begin
                reg_dst_o   = 1'b1;
                reg_write_s = 1'b1;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b001;
                pc_source_o = 2'b01;
                pc_write_s  = ((op_i == 6'h04) && zero_i) || ((op_i == 6'h05) && !zero_i);
            end
            JUMP: begin
                pc_source_o = 2'b10;
                pc_write_s  = 1'b1;
            end
            I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = (op_i == 6'h0A) ? 3'b011 : 3'b000;
            end
            I_WB:     reg_write_s = 1'b1;
            ERR:      err_o = 1'b1;
            default:  err_o = 1'b1;
        endcase
    end

    assign pc_write_o  = pc_write_s  & ~rst_i;
    assign ir_write_o  = ir_write_s  & ~rst_i;
    assign reg_write_o = reg_write_s & ~rst_i;
    assign mem_read_o  = mem_read_s  & ~rst_i;
    assign mem_write_o = mem_write_s & ~rst_i;
    assign state_o     = state_q;

`ifdef MULTI_CYCLE_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic        retire_s;

    assign retire_s = (state_d == FETCH) &&
                      ((state_q == MEM_WB) || (state_q == MEM_WR) || (state_q == R_WB) ||
                       (state_q == I_WB) || (state_q == BRANCH) || (state_q == JUMP));

    // Performance counter next values
    always_comb begin
        cycle_cnt_d = (state_q != ERR) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        instr_cnt_d = retire_s ? instr_cnt_q + 32'd1 : instr_cnt_q;
    end

    // Performance counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;
`else
    assign cycle_cnt_o = 32'd0;
    assign instr_cnt_o = 32'd0;
`endif

endmodule
